morse_tx_param: RTL and testbench
=================================

# morse_tx_param

Parametrised Morse-code character transmitter: accepts one character per valid/ready handshake (code bits plus symbol length) and drives a single LED output with dot, dash, inter-symbol, inter-character and word-space timing, all measured in a programmable unit length. Replaces the fixed-timing transmitter plus separate code register, LED FSM and space counter with one self-contained block. The host feeds characters from its character buffer; `led_drv` goes straight to the board LED.

## Interface
- CODE_W, 8: maximum symbols per character; width of `charcode_data`.
- LEN_W, 4: width of `charlen_data`; must satisfy 2^LEN_W > CODE_W.
- UNIT_CYC, 4: clock cycles per Morse unit; ≥ 1.
- DASH_UNITS, 3: dash mark length in units.
- SYM_GAP_UNITS, 1: gap between symbols of one character.
- CHAR_GAP_UNITS, 3: gap after the last symbol of a character.
- WORD_GAP_UNITS, 7: off time for a space character (len = 0).

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- tx_en  in  1  1 = run; 0 = freeze timing (pause).
- char_vald  in  1  character valid.
- charcode_data  in  CODE_W  symbol bits; 1 = dash, 0 = dot; sent from bit len-1 down to bit 0.
- charlen_data  in  LEN_W  symbol count; 0 = word space.
- char_next  out  1  ready; high only in IDLE with tx_en = 1.
- led_drv  out  1  registered LED drive; 1 = on.
- char_done  out  1  one-cycle pulse when a character (or space) finishes.

## Operation
- States: IDLE, MARK, GAP, SPACE.
- Accept when `char_vald & char_next` at a rising edge. Code and length are captured internally; inputs may change afterwards.
- Length handling: `charlen_data > CODE_W` is clamped to CODE_W. Length 0 goes to SPACE; otherwise the block goes to MARK on the first symbol.
- MARK: `led_drv` = 1 for 1 unit (dot) or DASH_UNITS units (dash). Then go to GAP.
- GAP: `led_drv` = 0. Length is SYM_GAP_UNITS if symbols remain, otherwise CHAR_GAP_UNITS. After GAP, go to MARK on the next symbol, or to IDLE.
- SPACE: `led_drv` = 0 for WORD_GAP_UNITS units, then go to IDLE.
- Timing counters:
  - Unit prescaler counts 0..UNIT_CYC-1.
  - Unit counter counts units within the current state.
  - Symbol index counts down from len-1.
  - Widths are sized from the parameters (clog2). No wraparound is allowed within a character.
- `char_done` pulses on the edge that enters IDLE from GAP or SPACE.
- tx_en = 0:
  - prescaler, unit counter, state and `led_drv` hold their values;
  - `char_next` = 0, so nothing is accepted;
  - on return to 1, timing resumes exactly where it stopped. A pause does not change the total active cycle count.
- Reset is asynchronous and takes effect mid-character: state IDLE, all counters 0, `led_drv` 0, `char_done` 0. The captured character is discarded.

## Timing
- Reset values: `led_drv` 0, `char_done` 0, `char_next` = tx_en (combinational from state IDLE and tx_en).
- Acceptance at edge E0 puts the block in MARK/SPACE at E0. `led_drv` is 1 from E0 for a first-symbol mark.
- A character of N total units (marks + gaps) holds `char_next` low for exactly N·UNIT_CYC cycles with tx_en held at 1. IDLE and `char_next` = 1 return at E0 + N·UNIT_CYC, and `char_done` is high for that one cycle.
- Back-to-back: with `char_vald` held, the next character is accepted on the same edge at which `char_next` is sampled high. Throughput is N·UNIT_CYC + 1 cycles per character.
- UNIT_CYC = 1 works: a dot is one cycle of `led_drv` = 1.

## Test plan
- 'A' (len 2, code 2'b01), UNIT_CYC 4, defaults -> `led_drv` high cycles 0–3, low 4–7, high 8–19, low 20–31; `char_done` at cycle 32; `char_next` low 32 cycles.
- Space (len 0) -> `led_drv` stays 0; `char_next` low 28 cycles; single `char_done` pulse.
- len 12 with CODE_W 8, code 8'hFF -> exactly 8 dashes sent; total 8·3 + 7·1 + 3 = 34 units = 136 cycles.
- tx_en low for 10 cycles in the middle of the dash of 'A' -> `led_drv` holds 1 for the pause; total `char_next`-low time 42 cycles; waveform otherwise identical.
- reset asserted at cycle 10 of 'A' -> `led_drv` 0 immediately (asynchronous); after release, `char_next` 1 and no `char_done` pulse.
- Back-to-back 'E' (len 1, code 0), then 'T' (len 1, code 1), `char_vald` held, UNIT_CYC 1 -> `led_drv` 1,0,0,0,(idle),1,1,1,0,0,0; `char_done` pulses at cycles 4 and 11.

Source files
------------

// File: rtl/morse_tx_param_if.sv
// Character handshake between the host character buffer and the Morse transmitter.
interface morse_tx_param_if #(
  parameter int CODE_W = 8,
  parameter int LEN_W  = 4
);
  logic              char_vald;
  logic [CODE_W-1:0] charcode_data;
  logic [LEN_W-1:0]  charlen_data;
  logic              char_next;

  modport master (output char_vald, charcode_data, charlen_data, input char_next);
  modport slave  (input char_vald, charcode_data, charlen_data, output char_next);
endinterface

// File: rtl/morse_tx_param.sv
// Morse character transmitter: one character per handshake, LED timing in programmable units.
//   state | meaning
//   IDLE  | waiting for a character; char_next = tx_en
//   MARK  | LED on for a dot (1 unit) or dash (DASH_UNITS)
//   GAP   | LED off; symbol gap if symbols remain, else character gap
//   SPACE | LED off for WORD_GAP_UNITS (length-0 character)
module morse_tx_param #(
  parameter int CODE_W         = 8,
  parameter int LEN_W          = 4,
  parameter int UNIT_CYC       = 4,
  parameter int DASH_UNITS     = 3,
  parameter int SYM_GAP_UNITS  = 1,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_en,
  morse_tx_param_if.slave       chr,
  output logic                  led_drv,
  output logic                  char_done
);

  localparam int MAX_A     = (DASH_UNITS > SYM_GAP_UNITS) ? DASH_UNITS : SYM_GAP_UNITS;
  localparam int MAX_B     = (CHAR_GAP_UNITS > WORD_GAP_UNITS) ? CHAR_GAP_UNITS : WORD_GAP_UNITS;
  localparam int MAX_UNITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int UCNT_W    = (MAX_UNITS > 1) ? $clog2(MAX_UNITS + 1) : 1;
  localparam int PRE_W     = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int IDX_W     = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  typedef enum logic [1:0] {IDLE, MARK, GAP, SPACE} state_t;

  state_t            state;
  logic [PRE_W-1:0]  pre;
  logic [UCNT_W-1:0] ucnt;
  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] code;
  logic [UCNT_W-1:0] units_tgt;
  logic [LEN_W-1:0]  len_c;
  logic              unit_last;

  assign chr.char_next = (state == IDLE) && tx_en;

  always_comb begin
    len_c = chr.charlen_data;
    if (chr.charlen_data > LEN_W'(CODE_W)) len_c = LEN_W'(CODE_W);
  end

  // Length of the current state in units; in GAP, idx still points at the symbol just sent.
  always_comb begin
    units_tgt = UCNT_W'(WORD_GAP_UNITS);
    case (state)
      MARK:    units_tgt = code[idx] ? UCNT_W'(DASH_UNITS) : UCNT_W'(1);
      GAP:     units_tgt = (idx != '0) ? UCNT_W'(SYM_GAP_UNITS) : UCNT_W'(CHAR_GAP_UNITS);
      default: units_tgt = UCNT_W'(WORD_GAP_UNITS);
    endcase
  end

  assign unit_last = (ucnt == units_tgt - 1'b1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pre       <= '0;
      ucnt      <= '0;
      idx       <= '0;
      code      <= '0;
      led_drv   <= 1'b0;
      char_done <= 1'b0;
    end else begin
      char_done <= 1'b0;
      if (tx_en) begin
        case (state)
          IDLE: begin
            if (chr.char_vald) begin
              code <= chr.charcode_data;
              idx  <= IDX_W'(len_c - 1'b1);
              pre  <= '0;
              ucnt <= '0;
              if (len_c == '0) begin
                state   <= SPACE;
                led_drv <= 1'b0;
              end else begin
                state   <= MARK;
                led_drv <= 1'b1;
              end
            end
          end
          default: begin
            if (pre == PRE_W'(UNIT_CYC - 1)) begin
              pre <= '0;
              if (unit_last) begin
                ucnt <= '0;
                case (state)
                  MARK: begin
                    state   <= GAP;
                    led_drv <= 1'b0;
                  end
                  GAP: begin
                    if (idx != '0) begin
                      idx     <= idx - 1'b1;
                      state   <= MARK;
                      led_drv <= 1'b1;
                    end else begin
                      state     <= IDLE;
                      char_done <= 1'b1;
                    end
                  end
                  default: begin
                    state     <= IDLE;
                    char_done <= 1'b1;
                  end
                endcase
              end else begin
                ucnt <= ucnt + 1'b1;
              end
            end else begin
              pre <= pre + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_param.sv
// Directed bench for morse_tx_param: one instance at UNIT_CYC 4, one at UNIT_CYC 1.
module tb_morse_tx_param;
  localparam int CODE_W = 8;
  localparam int LEN_W  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tx_en = 1'b1;
  logic led4, done4, led1, done1;

  morse_tx_param_if #(.CODE_W(CODE_W), .LEN_W(LEN_W)) bus4 ();
  morse_tx_param_if #(.CODE_W(CODE_W), .LEN_W(LEN_W)) bus1 ();

  morse_tx_param #(.CODE_W(CODE_W), .LEN_W(LEN_W), .UNIT_CYC(4)) dut4 (
    .clock(clock), .reset(reset), .tx_en(tx_en), .chr(bus4),
    .led_drv(led4), .char_done(done4));

  morse_tx_param #(.CODE_W(CODE_W), .LEN_W(LEN_W), .UNIT_CYC(1)) dut1 (
    .clock(clock), .reset(reset), .tx_en(tx_en), .chr(bus1),
    .led_drv(led1), .char_done(done1));

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;
  logic led_w  [0:199];
  logic nxt_w  [0:199];
  logic done_w [0:199];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] code, input logic [3:0] len);
    @(negedge clock);
    if (sel) begin
      bus1.charcode_data = code; bus1.charlen_data = len; bus1.char_vald = 1'b1;
    end else begin
      bus4.charcode_data = code; bus4.charlen_data = len; bus4.char_vald = 1'b1;
    end
  endtask

  // Records n cycles after acceptance; at cycle 0 loads the follow-on character,
  // drops valid after cycle drop_at, and pauses tx_en for 10 edges after cycle pause_at.
  task automatic capture(input bit sel, input int n, input int drop_at, input int pause_at,
                         input logic [7:0] code2, input logic [3:0] len2);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      led_w[k]  = sel ? led1 : led4;
      nxt_w[k]  = sel ? bus1.char_next : bus4.char_next;
      done_w[k] = sel ? done1 : done4;
      if (k == 0) begin
        if (sel) begin bus1.charcode_data = code2; bus1.charlen_data = len2; end
        else begin bus4.charcode_data = code2; bus4.charlen_data = len2; end
      end
      if (k == drop_at) begin bus4.char_vald = 1'b0; bus1.char_vald = 1'b0; end
      if (k == pause_at) tx_en = 1'b0;
      if (k == pause_at + 10) tx_en = 1'b1;
    end
  endtask

  function automatic logic exp_a(input int k);
    return (k < 4) || (k >= 8 && k < 20);
  endfunction

  initial begin
    int n_high, n_rise, n_low, n_done;
    logic prev;
    logic exp_e_t [0:11];
    exp_e_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    bus4.char_vald = 1'b0; bus4.charcode_data = '0; bus4.charlen_data = '0;
    bus1.char_vald = 1'b0; bus1.charcode_data = '0; bus1.charlen_data = '0;
    #1;
    chk("reset led", led4, 1'b0);
    chk("reset done", done4, 1'b0);
    chk("reset next", bus4.char_next, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("idle next", bus4.char_next, 1'b1);
    tx_en = 1'b0;
    #1;
    chk("paused next", bus4.char_next, 1'b0);
    tx_en = 1'b1;

    // 'A' = dot dash
    send(1'b0, 8'b01, 4'd2);
    capture(1'b0, 34, 0, -1000, 8'b01, 4'd2);
    for (int k = 0; k < 34; k++) begin
      chk($sformatf("A led c%0d", k), led_w[k], exp_a(k));
      chk($sformatf("A next c%0d", k), nxt_w[k], k >= 32);
      chk($sformatf("A done c%0d", k), done_w[k], k == 32);
    end

    // word space
    send(1'b0, 8'hA5, 4'd0);
    capture(1'b0, 30, 0, -1000, 8'hA5, 4'd0);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("SP led c%0d", k), led_w[k], 1'b0);
      chk($sformatf("SP next c%0d", k), nxt_w[k], k >= 28);
      chk($sformatf("SP done c%0d", k), done_w[k], k == 28);
    end

    // over-length character clamps to 8 dashes
    send(1'b0, 8'hFF, 4'd12);
    capture(1'b0, 138, 0, -1000, 8'hFF, 4'd12);
    n_high = 0; n_rise = 0; n_low = 0; n_done = 0; prev = 1'b0;
    for (int k = 0; k < 138; k++) begin
      if (led_w[k]) n_high++;
      if (led_w[k] && !prev) n_rise++;
      if (!nxt_w[k]) n_low++;
      if (done_w[k]) n_done++;
      prev = led_w[k];
    end
    chk("clamp led high cycles", n_high, 96);
    chk("clamp dash count", n_rise, 8);
    chk("clamp next low cycles", n_low, 136);
    chk("clamp done count", n_done, 1);
    chk("clamp done cycle", done_w[136], 1'b1);

    // 'A' with a 10-cycle pause inside the dash
    send(1'b0, 8'b01, 4'd2);
    capture(1'b0, 44, 0, 12, 8'b01, 4'd2);
    for (int k = 0; k < 44; k++) begin
      chk($sformatf("PA led c%0d", k), led_w[k],
          (k < 13) ? exp_a(k) : (k < 23) ? 1'b1 : exp_a(k - 10));
      chk($sformatf("PA next c%0d", k), nxt_w[k], k >= 42);
      chk($sformatf("PA done c%0d", k), done_w[k], k == 42);
    end

    // asynchronous reset in the middle of 'A'
    send(1'b0, 8'b01, 4'd2);
    capture(1'b0, 11, 0, -1000, 8'b01, 4'd2);
    chk("RST led before", led4, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("RST led async", led4, 1'b0);
    chk("RST done async", done4, 1'b0);
    chk("RST next async", bus4.char_next, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    n_high = 0; n_done = 0; n_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (led4) n_high++;
      if (done4) n_done++;
      if (!bus4.char_next) n_low++;
    end
    chk("RST led after", n_high, 0);
    chk("RST done after", n_done, 0);
    chk("RST next low after", n_low, 0);

    // back-to-back 'E' then 'T' at one cycle per unit
    send(1'b1, 8'b0, 4'd1);
    capture(1'b1, 12, 5, -1000, 8'b1, 4'd1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("ET led c%0d", k), led_w[k], exp_e_t[k]);
      chk($sformatf("ET done c%0d", k), done_w[k], (k == 4) || (k == 11));
      chk($sformatf("ET next c%0d", k), nxt_w[k], (k == 4) || (k == 11));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
